// File: rtl/generador_ventana_pixeles.sv
// generador_ventana_pixeles: builds 3x3 or 5x5 windows from a raster pixel stream using line buffers.
// It holds each window until the convolver acknowledges it. Optional macro: VENTANA_CONTADOR_EN.
module generador_ventana_pixeles #(
    parameter int BITS_PIXEL   = 8,
    parameter int BITS_DIM     = 10,
    parameter int ANCHO_MAX    = 640,
    parameter int BITS_MASCARA = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    inicio,
    input  logic [BITS_DIM-1:0]     ancho_imagen,
    input  logic [BITS_DIM-1:0]     alto_imagen,
    input  logic [BITS_MASCARA-1:0] tamano_mascara,
    input  logic [BITS_PIXEL-1:0]   pixel_entrada,
    input  logic                    pixel_valido,
    output logic                    entrada_lista,
    input  logic                    pixel_calculado,
    output logic [BITS_PIXEL-1:0]   pixel_value_1,
    output logic [BITS_PIXEL-1:0]   pixel_value_2,
    output logic [BITS_PIXEL-1:0]   pixel_value_3,
    output logic [BITS_PIXEL-1:0]   pixel_value_4,
    output logic [BITS_PIXEL-1:0]   pixel_value_5,
    output logic [BITS_PIXEL-1:0]   pixel_value_6,
    output logic [BITS_PIXEL-1:0]   pixel_value_7,
    output logic [BITS_PIXEL-1:0]   pixel_value_8,
    output logic [BITS_PIXEL-1:0]   pixel_value_9,
    output logic [BITS_PIXEL-1:0]   pixel_value_10,
    output logic [BITS_PIXEL-1:0]   pixel_value_11,
    output logic [BITS_PIXEL-1:0]   pixel_value_12,
    output logic [BITS_PIXEL-1:0]   pixel_value_13,
    output logic [BITS_PIXEL-1:0]   pixel_value_14,
    output logic [BITS_PIXEL-1:0]   pixel_value_15,
    output logic [BITS_PIXEL-1:0]   pixel_value_16,
    output logic [BITS_PIXEL-1:0]   pixel_value_17,
    output logic [BITS_PIXEL-1:0]   pixel_value_18,
    output logic [BITS_PIXEL-1:0]   pixel_value_19,
    output logic [BITS_PIXEL-1:0]   pixel_value_20,
    output logic [BITS_PIXEL-1:0]   pixel_value_21,
    output logic [BITS_PIXEL-1:0]   pixel_value_22,
    output logic [BITS_PIXEL-1:0]   pixel_value_23,
    output logic [BITS_PIXEL-1:0]   pixel_value_24,
    output logic [BITS_PIXEL-1:0]   pixel_value_25,
    output logic                    ventana_pixeles_lista,
`ifdef VENTANA_CONTADOR_EN
    output logic [19:0]             contador_ventanas,
`endif
    output logic                    imagen_terminada
);

    typedef enum logic [1:0] {
        REPOSO         = 2'd0,
        ESPERA_PIXEL   = 2'd1,
        ESPERA_CALCULO = 2'd2,
        FIN            = 2'd3
    } estado_t;

    localparam logic [BITS_DIM-1:0] ANCHO_MAX_L = BITS_DIM'(ANCHO_MAX);
    localparam logic [BITS_DIM-1:0] DIM_1       = BITS_DIM'(1);
    localparam logic [BITS_DIM-1:0] DIM_2       = BITS_DIM'(2);
    localparam logic [BITS_DIM-1:0] DIM_3       = BITS_DIM'(3);
    localparam logic [BITS_DIM-1:0] DIM_4       = BITS_DIM'(4);
    localparam logic [BITS_DIM-1:0] DIM_5       = BITS_DIM'(5);

    estado_t                estado_r;
    estado_t                estado_next_s;
    logic [BITS_DIM-1:0]    ancho_r;
    logic [BITS_DIM-1:0]    alto_r;
    logic [BITS_DIM-1:0]    col_r;
    logic [BITS_DIM-1:0]    row_r;
    logic                   n5_r;
    logic                   ultimo_r;
    logic [BITS_PIXEL-1:0]  pv_r [0:24];
    logic [BITS_PIXEL-1:0]  lb_r [0:3][0:ANCHO_MAX-1];
    logic [BITS_PIXEL-1:0]  col_nueva_s [0:4];
    logic                   entrada_lista_r;
    logic                   ventana_r;
    logic                   terminada_r;
    logic                   entrada_lista_s;
    logic                   ventana_s;
    logic                   terminada_s;
    logic                   tam5_s;
    logic [BITS_DIM-1:0]    n_ini_s;
    logic [BITS_DIM-1:0]    n_m1_s;
    logic                   inicio_ok_s;
    logic                   acepta_s;
    logic                   fin_col_s;
    logic                   ultimo_px_s;
    logic                   ventana_ok_s;

    assign tam5_s      = (tamano_mascara == BITS_MASCARA'(5));
    assign n_ini_s     = tam5_s ? DIM_5 : DIM_3;
    assign inicio_ok_s = inicio && (ancho_imagen >= n_ini_s) && (ancho_imagen <= ANCHO_MAX_L)
                         && (alto_imagen >= n_ini_s);
    // A valid restart takes priority over a pixel offered in the same cycle
    assign acepta_s    = pixel_valido && (estado_r == ESPERA_PIXEL) && !inicio_ok_s;
    assign n_m1_s      = n5_r ? DIM_4 : DIM_2;
    assign fin_col_s   = (col_r == (ancho_r - DIM_1));
    assign ultimo_px_s = fin_col_s && (row_r == (alto_r - DIM_1));
    assign ventana_ok_s = (row_r >= n_m1_s) && (col_r >= n_m1_s);

    // New window column: line-buffer taps (oldest row first) with the incoming pixel at the bottom
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            col_nueva_s[k] = lb_r[k][col_r];
        end
        col_nueva_s[4] = pixel_entrada;
    end

    // Line buffers: each accepted pixel pushes its column one row further up the chain
    always_ff @(posedge clk) begin
        if (acepta_s) begin
            for (int k = 0; k < 3; k++) begin
                lb_r[k][col_r] <= lb_r[k+1][col_r];
            end
            lb_r[3][col_r] <= pixel_entrada;
        end
    end

    // Frame configuration and raster position counters
    always_ff @(posedge clk) begin
        if (reset) begin
            ancho_r  <= '0;
            alto_r   <= '0;
            n5_r     <= 1'b0;
            col_r    <= '0;
            row_r    <= '0;
            ultimo_r <= 1'b0;
        end else if (inicio_ok_s) begin
            ancho_r  <= ancho_imagen;
            alto_r   <= alto_imagen;
            n5_r     <= tam5_s;
            col_r    <= '0;
            row_r    <= '0;
            ultimo_r <= 1'b0;
        end else if (acepta_s) begin
            ultimo_r <= ultimo_px_s;
            if (fin_col_s) begin
                col_r <= '0;
                row_r <= row_r + DIM_1;
            end else begin
                col_r <= col_r + DIM_1;
            end
        end
    end

    // Window registers: shift one column left and insert the new column on the right
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 25; i++) begin
                pv_r[i] <= '0;
            end
        end else if (acepta_s) begin
            if (n5_r) begin
                for (int r = 0; r < 5; r++) begin
                    for (int c = 0; c < 4; c++) begin
                        pv_r[5*r+c] <= pv_r[5*r+c+1];
                    end
                    pv_r[5*r+4] <= col_nueva_s[r];
                end
            end else begin
                for (int r = 0; r < 3; r++) begin
                    for (int c = 0; c < 2; c++) begin
                        pv_r[3*r+c] <= pv_r[3*r+c+1];
                    end
                    pv_r[3*r+2] <= col_nueva_s[r+2];
                end
                for (int i = 9; i < 25; i++) begin
                    pv_r[i] <= '0;
                end
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            estado_r <= REPOSO;
        end else begin
            estado_r <= estado_next_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        estado_next_s = estado_r;
        if (inicio_ok_s) begin
            estado_next_s = ESPERA_PIXEL;
        end else begin
            case (estado_r)
                REPOSO: begin
                    estado_next_s = REPOSO;
                end
                ESPERA_PIXEL: begin
                    if (acepta_s && ventana_ok_s) begin
                        estado_next_s = ESPERA_CALCULO;
                    end else if (acepta_s && ultimo_px_s) begin
                        estado_next_s = FIN;
                    end else begin
                        estado_next_s = ESPERA_PIXEL;
                    end
                end
                ESPERA_CALCULO: begin
                    if (pixel_calculado && ultimo_r) begin
                        estado_next_s = FIN;
                    end else if (pixel_calculado) begin
                        estado_next_s = ESPERA_PIXEL;
                    end else begin
                        estado_next_s = ESPERA_CALCULO;
                    end
                end
                FIN: begin
                    estado_next_s = FIN;
                end
                default: begin
                    estado_next_s = REPOSO;
                end
            endcase
        end
    end

    // FSM outputs, decoded from the next state so the registered copies align with the state
    always_comb begin
        entrada_lista_s = 1'b0;
        ventana_s       = 1'b0;
        terminada_s     = 1'b0;
        case (estado_next_s)
            REPOSO: begin
                entrada_lista_s = 1'b0;
            end
            ESPERA_PIXEL: begin
                entrada_lista_s = 1'b1;
            end
            ESPERA_CALCULO: begin
                ventana_s = (estado_r != ESPERA_CALCULO);
            end
            FIN: begin
                terminada_s = 1'b1;
            end
            default: begin
                entrada_lista_s = 1'b0;
            end
        endcase
    end

    // Registered control outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            entrada_lista_r <= 1'b0;
            ventana_r       <= 1'b0;
            terminada_r     <= 1'b0;
        end else begin
            entrada_lista_r <= entrada_lista_s;
            ventana_r       <= ventana_s;
            terminada_r     <= terminada_s;
        end
    end

`ifdef VENTANA_CONTADOR_EN
    logic [19:0] contador_r;

    // Saturating count of emitted windows, rising together with each window pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            contador_r <= 20'd0;
        end else if (inicio_ok_s) begin
            contador_r <= 20'd0;
        end else if (ventana_s && (contador_r != 20'hFFFFF)) begin
            contador_r <= contador_r + 20'd1;
        end
    end

    assign contador_ventanas = contador_r;
`endif

    assign entrada_lista         = entrada_lista_r;
    assign ventana_pixeles_lista = ventana_r;
    assign imagen_terminada      = terminada_r;

    assign pixel_value_1  = pv_r[0];
    assign pixel_value_2  = pv_r[1];
    assign pixel_value_3  = pv_r[2];
    assign pixel_value_4  = pv_r[3];
    assign pixel_value_5  = pv_r[4];
    assign pixel_value_6  = pv_r[5];
    assign pixel_value_7  = pv_r[6];
    assign pixel_value_8  = pv_r[7];
    assign pixel_value_9  = pv_r[8];
    assign pixel_value_10 = pv_r[9];
    assign pixel_value_11 = pv_r[10];
    assign pixel_value_12 = pv_r[11];
    assign pixel_value_13 = pv_r[12];
    assign pixel_value_14 = pv_r[13];
    assign pixel_value_15 = pv_r[14];
    assign pixel_value_16 = pv_r[15];
    assign pixel_value_17 = pv_r[16];
    assign pixel_value_18 = pv_r[17];
    assign pixel_value_19 = pv_r[18];
    assign pixel_value_20 = pv_r[19];
    assign pixel_value_21 = pv_r[20];
    assign pixel_value_22 = pv_r[21];
    assign pixel_value_23 = pv_r[22];
    assign pixel_value_24 = pv_r[23];
    assign pixel_value_25 = pv_r[24];

endmodule

// File: tb/tb_generador_ventana_pixeles.sv
// Bench for generador_ventana_pixeles: table of whole-frame scenarios with hand-computed first/last
// windows, plus hand-written sequences for rejected starts, mid-frame reset and mid-frame size change.
module tb_generador_ventana_pixeles;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset;
    logic             inicio;
    logic [9:0]       ancho_imagen;
    logic [9:0]       alto_imagen;
    logic [2:0]       tamano_mascara;
    logic [7:0]       pixel_entrada;
    logic             pixel_valido;
    logic             entrada_lista;
    logic             pixel_calculado;
    logic             ventana_pixeles_lista;
    logic             imagen_terminada;
    logic [0:24][7:0] pv;
`ifdef VENTANA_CONTADOR_EN
    logic [19:0]      contador_ventanas;
`endif

    generador_ventana_pixeles dut (
        .clk(clk), .reset(reset), .inicio(inicio),
        .ancho_imagen(ancho_imagen), .alto_imagen(alto_imagen), .tamano_mascara(tamano_mascara),
        .pixel_entrada(pixel_entrada), .pixel_valido(pixel_valido), .entrada_lista(entrada_lista),
        .pixel_calculado(pixel_calculado),
        .pixel_value_1(pv[0]),   .pixel_value_2(pv[1]),   .pixel_value_3(pv[2]),
        .pixel_value_4(pv[3]),   .pixel_value_5(pv[4]),   .pixel_value_6(pv[5]),
        .pixel_value_7(pv[6]),   .pixel_value_8(pv[7]),   .pixel_value_9(pv[8]),
        .pixel_value_10(pv[9]),  .pixel_value_11(pv[10]), .pixel_value_12(pv[11]),
        .pixel_value_13(pv[12]), .pixel_value_14(pv[13]), .pixel_value_15(pv[14]),
        .pixel_value_16(pv[15]), .pixel_value_17(pv[16]), .pixel_value_18(pv[17]),
        .pixel_value_19(pv[18]), .pixel_value_20(pv[19]), .pixel_value_21(pv[20]),
        .pixel_value_22(pv[21]), .pixel_value_23(pv[22]), .pixel_value_24(pv[23]),
        .pixel_value_25(pv[24]),
        .ventana_pixeles_lista(ventana_pixeles_lista),
`ifdef VENTANA_CONTADOR_EN
        .contador_ventanas(contador_ventanas),
`endif
        .imagen_terminada(imagen_terminada)
    );

    typedef struct {
        int               sz;
        int               w;
        int               h;
        int               dly;
        int               exp_n;
        bit               hold;
        logic [0:24][7:0] f;
        logic [0:24][7:0] l;
    } frame_vec_t;

    typedef struct {
        int sz;
        int w;
        int h;
    } bad_vec_t;

    frame_vec_t       fv [4];
    bad_vec_t         bv [4];
    int               total = 0;
    int               bad = 0;
    int               nwin;
    int               px;
    logic [0:24][7:0] got_f;
    logic [0:24][7:0] got_l;
    logic [0:24][7:0] held;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", nm, got, exp);
        end
    endtask

    task automatic chkv(input string nm, input logic [0:24][7:0] got, input logic [0:24][7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", nm, got, exp);
        end
    endtask

    // Window k in emission order on an image whose pixel (r,c) is r*w+c+1
    function automatic logic [0:24][7:0] exp_win(input int n, input int w, input int k);
        logic [0:24][7:0] e;
        int ww;
        int wr;
        int wc;
        e  = '0;
        ww = w - n + 1;
        wr = k / ww;
        wc = k % ww;
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < n; j++) begin
                e[i*n+j] = 8'((wr + i) * w + wc + j + 1);
            end
        end
        return e;
    endfunction

    task automatic run_frame(input int idx, input bit mask_mid, input int stop_after);
        int               cyc;
        int               wait_cnt;
        bit               acc;
        logic [0:24][7:0] e;
        nwin = 0;
        px = 0;
        cyc = 0;
        wait_cnt = -1;
        tamano_mascara  = 3'(fv[idx].sz);
        ancho_imagen    = 10'(fv[idx].w);
        alto_imagen     = 10'(fv[idx].h);
        inicio          = 1'b1;
        pixel_valido    = 1'b1;
        pixel_entrada   = 8'd1;
        pixel_calculado = 1'b0;
        @(posedge clk); #1;
        inicio = 1'b0;
        chk("start_lista", entrada_lista, 1);
        chk("start_term_clear", imagen_terminada, 0);
        while (imagen_terminada !== 1'b1 && cyc < 2000 && !(stop_after > 0 && px >= stop_after)) begin
            acc = pixel_valido && (entrada_lista === 1'b1);
            @(posedge clk); #1;
            cyc++;
            pixel_calculado = 1'b0;
            if (acc) begin
                px++;
                pixel_entrada = 8'(px + 1);
            end
            if (mask_mid && px >= 5) tamano_mascara = 3'd5;
            if (ventana_pixeles_lista === 1'b1) begin
                e = exp_win(fv[idx].sz, fv[idx].w, nwin);
                chkv("window", pv, e);
                if (nwin == 0) got_f = pv;
                got_l = pv;
                held = pv;
                nwin++;
                wait_cnt = fv[idx].dly;
            end else if (wait_cnt > 0) begin
                wait_cnt--;
                if (fv[idx].hold) begin
                    chkv("hold_window", pv, held);
                    chk("hold_lista", entrada_lista, 0);
                end
            end
            if (wait_cnt == 0) begin
                pixel_calculado = 1'b1;
                wait_cnt = -1;
            end
        end
        pixel_valido = 1'b0;
        pixel_calculado = 1'b0;
        if (stop_after == 0) begin
            chk("frame_done_in_time", 32'(cyc < 2000), 1);
            chk("n_windows", nwin, fv[idx].exp_n);
            chk("pixels_consumed", px, fv[idx].w * fv[idx].h);
            chkv("first_window", got_f, fv[idx].f);
            chkv("last_window", got_l, fv[idx].l);
            chk("fin_lista", entrada_lista, 0);
            @(posedge clk); #1;
            chk("term_held", imagen_terminada, 1);
        end
    endtask

    initial begin
        fv[0] = '{3, 4, 4, 2, 4, 1'b0,
                  {8'd1, 8'd2, 8'd3, 8'd5, 8'd6, 8'd7, 8'd9, 8'd10, 8'd11, {16{8'd0}}},
                  {8'd6, 8'd7, 8'd8, 8'd10, 8'd11, 8'd12, 8'd14, 8'd15, 8'd16, {16{8'd0}}}};
        fv[1] = '{5, 6, 6, 1, 4, 1'b0,
                  {8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd7, 8'd8, 8'd9, 8'd10, 8'd11,
                   8'd13, 8'd14, 8'd15, 8'd16, 8'd17, 8'd19, 8'd20, 8'd21, 8'd22, 8'd23,
                   8'd25, 8'd26, 8'd27, 8'd28, 8'd29},
                  {8'd8, 8'd9, 8'd10, 8'd11, 8'd12, 8'd14, 8'd15, 8'd16, 8'd17, 8'd18,
                   8'd20, 8'd21, 8'd22, 8'd23, 8'd24, 8'd26, 8'd27, 8'd28, 8'd29, 8'd30,
                   8'd32, 8'd33, 8'd34, 8'd35, 8'd36}};
        fv[2] = '{3, 5, 3, 0, 3, 1'b0,
                  {8'd1, 8'd2, 8'd3, 8'd6, 8'd7, 8'd8, 8'd11, 8'd12, 8'd13, {16{8'd0}}},
                  {8'd3, 8'd4, 8'd5, 8'd8, 8'd9, 8'd10, 8'd13, 8'd14, 8'd15, {16{8'd0}}}};
        fv[3] = '{3, 4, 4, 5, 4, 1'b1,
                  {8'd1, 8'd2, 8'd3, 8'd5, 8'd6, 8'd7, 8'd9, 8'd10, 8'd11, {16{8'd0}}},
                  {8'd6, 8'd7, 8'd8, 8'd10, 8'd11, 8'd12, 8'd14, 8'd15, 8'd16, {16{8'd0}}}};
        bv[0] = '{3, 2, 4};
        bv[1] = '{3, 641, 4};
        bv[2] = '{5, 4, 6};
        bv[3] = '{3, 4, 2};

        reset = 1'b1;
        inicio = 1'b0;
        ancho_imagen = 10'd0;
        alto_imagen = 10'd0;
        tamano_mascara = 3'd0;
        pixel_entrada = 8'd0;
        pixel_valido = 1'b0;
        pixel_calculado = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_lista", entrada_lista, 0);
        chk("reset_ventana", ventana_pixeles_lista, 0);
        chk("reset_term", imagen_terminada, 0);
        chkv("reset_window", pv, '0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Rejected starts from idle leave the block idle
        for (int i = 0; i < 4; i++) begin
            tamano_mascara = 3'(bv[i].sz);
            ancho_imagen = 10'(bv[i].w);
            alto_imagen = 10'(bv[i].h);
            inicio = 1'b1;
            pixel_valido = 1'b1;
            @(posedge clk); #1;
            inicio = 1'b0;
            chk("bad_inicio_lista", entrada_lista, 0);
            @(posedge clk); #1;
            chk("bad_inicio_lista_later", entrada_lista, 0);
        end
        pixel_valido = 1'b0;

        for (int i = 0; i < 4; i++) begin
            run_frame(i, 1'b0, 0);
        end

        // A rejected start while finished keeps the frame-done flag
        tamano_mascara = 3'(bv[0].sz);
        ancho_imagen = 10'(bv[0].w);
        alto_imagen = 10'(bv[0].h);
        inicio = 1'b1;
        @(posedge clk); #1;
        inicio = 1'b0;
        chk("fin_bad_inicio_term", imagen_terminada, 1);
        chk("fin_bad_inicio_lista", entrada_lista, 0);

        // Reset after pixel 7, then a full rerun of the 4x4 frame
        run_frame(0, 1'b0, 7);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("midreset_lista", entrada_lista, 0);
        chk("midreset_ventana", ventana_pixeles_lista, 0);
        chk("midreset_term", imagen_terminada, 0);
        chkv("midreset_window", pv, '0);
        reset = 1'b0;
        @(posedge clk); #1;
        run_frame(0, 1'b0, 0);

        // Mask size changed mid-frame must have no effect
        run_frame(0, 1'b1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
